// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request and response channels,
// fixed WAIT_STATES latency, byte-enable stores. Optional macro: DMEM_ALIGN_CHK_EN.
//
// state  | meaning
// S_IDLE | ready for a request
// S_WAIT | counting wait states
// S_RESP | response presented, held until rsp_ready
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                      clk1,
    input  logic                      reset1,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic                   we_q, mis_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BE_W-1:0]        be_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q;
    logic                   accept, commit, req_mis;
    logic                   c_we, c_mis;
    logic [IDX_W-1:0]       c_idx;
    logic [DATA_WIDTH-1:0]  c_wdata;
    logic [BE_W-1:0]        c_be;
    logic                   unused_addr_bits;
    logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
    assign req_mis = (req_addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    // With zero wait states the commit edge is the accept edge, so take the live request.
    always_comb begin
        c_we    = we_q;
        c_mis   = mis_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        if (state == S_IDLE) begin
            c_we    = req_we;
            c_mis   = req_mis;
            c_idx   = req_addr[IDX_W+1:2];
            c_wdata = req_wdata;
            c_be    = req_be;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt = WAIT_LOAD;
                    if (WAIT_STATES == 0) state_nxt = S_RESP;
                    else                  state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign commit = (state_nxt == S_RESP) && (state != S_RESP);

    always_ff @(posedge clk1) begin
        if (reset1) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                mis_q   <= req_mis;
                idx_q   <= req_addr[IDX_W+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (commit) begin
                rdata_q <= (!c_we && !c_mis) ? mem[c_idx] : '0;
                err_q   <= c_mis;
            end
        end
    end

    // Storage is not reset; a reset on the commit edge cancels the write.
    always_ff @(posedge clk1) begin
        if (!reset1 && commit && c_we && !c_mis) begin
            for (int b = 0; b < BE_W; b++) begin
                if (c_be[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios then random traffic against a word-array model.
module tb_dmem_responder;
    localparam int WS = 2;

    logic        clk1 = 1'b0;
    logic        reset1 = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [256];
    logic [31:0] last_rd;
    logic        last_err;

    always #5 clk1 = ~clk1;

    dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
        .clk1(clk1), .reset1(reset1),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: word-addressed array, address wraps modulo 1 KiB, misaligned handling by macro.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be, output logic [31:0] rd, output logic err);
        int w;
        w   = int'((addr >> 2) % 256);
        err = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
        err = (addr % 4) != 0;
`endif
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = model_mem[w];
            end
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be);
        @(negedge clk1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk1);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk1);
        #1 req_valid = 1'b0;
    endtask

    task automatic await_rsp(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be);
        int lat;
        logic [31:0] erd;
        logic eerr;
        lat = 0;
        do begin
            @(negedge clk1);
            lat++;
        end while (!rsp_valid && lat < 40);
        chk("latency", 32'(lat), 32'(WS + 1));
        model_apply(we, addr, wd, be, erd, eerr);
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        last_rd  = rsp_rdata;
        last_err = rsp_err;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk1);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
        drive_req(we, addr, wd, be);
        wait_accept();
        await_rsp(we, addr, wd, be);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk1);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, last_rd);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        release_rsp();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        repeat (3) @(posedge clk1);
        #1 reset1 = 1'b0;
        @(negedge clk1);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);

        // Give every word a defined value so random loads have a known answer.
        for (int i = 0; i < 256; i++) txn(1'b1, 32'(i * 4), 32'h0, 4'hF, 0);

        // Full-word store then load.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("t1_load", last_rd, 32'hDEADBEEF);
        chk("t1_err", 32'(last_err), 32'd0);

        // Single byte-lane store.
        txn(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("t2_load", last_rd, 32'hDEADABEF);

        // Backpressure with a competing request pending.
        drive_req(1'b0, 32'h10, 32'h0, 4'h0);
        wait_accept();
        await_rsp(1'b0, 32'h10, 32'h0, 4'h0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h77777777; req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk1);
            chk("t3_valid", 32'(rsp_valid), 32'd1);
            chk("t3_rdata", rsp_rdata, 32'hDEADABEF);
            chk("t3_ready", 32'(req_ready), 32'd0);
        end
        release_rsp();
        @(negedge clk1);
        chk("t3_ready_after", 32'(req_ready), 32'd1);
        @(posedge clk1);
        #1 req_valid = 1'b0;
        await_rsp(1'b1, 32'h30, 32'h77777777, 4'hF);
        release_rsp();
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0);
        chk("t3_store_landed", last_rd, 32'h77777777);

        // Reset while a store is waiting: store must be dropped.
        txn(1'b1, 32'h20, 32'h11111111, 4'hF, 0);
        drive_req(1'b1, 32'h20, 32'h22222222, 4'hF);
        wait_accept();
        reset1 = 1'b1;
        @(posedge clk1);
        #1 reset1 = 1'b0;
        @(negedge clk1);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t4_req_ready", 32'(req_ready), 32'd1);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
        chk("t4_load", last_rd, 32'h11111111);

        // Address aliasing.
        txn(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0);
        txn(1'b0, 32'h000, 32'h0, 4'h0, 0);
        chk("t5_alias", last_rd, 32'hCAFEF00D);

        // Misaligned store.
        txn(1'b1, 32'h13, 32'h55555555, 4'hF, 0);
`ifdef DMEM_ALIGN_CHK_EN
        chk("t6_err", 32'(last_err), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("t6_load", last_rd, 32'hDEADABEF);
`else
        chk("t6_err", 32'(last_err), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("t6_load", last_rd, 32'h55555555);
`endif

        // Random traffic with random response backpressure.
        for (int i = 0; i < 200; i++) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
